// File: rtl/lc4_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// Read responses are steered back to their requester through a latency-matched shift pipeline.
module lc4_mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic                 mem_dre,
  output logic [ADDR_W-1:0]    mem_draddr,
  output logic                 mem_dwe,
  output logic [ADDR_W-1:0]    mem_dwaddr,
  output logic [WORD_SIZE-1:0] mem_din,
  input  logic [WORD_SIZE-1:0] mem_dout,
  output logic [15:0]          conflict_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                 en;
  logic                 ptr;
  logic                 gnt_any;
  logic                 gnt_we;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [WORD_SIZE-1:0] gnt_wdata;
  logic [RD_LAT-1:0]    vld_p;
  logic [RD_LAT-1:0]    id_p;
  logic                 head_vld;
  logic                 head_id;

  // ptr=1 gives B priority under contention
  always_comb begin
    en        = gwe & rst;
    a_gnt     = en & a_req & (~b_req | ~ptr);
    b_gnt     = en & b_req & (~a_req | ptr);
    gnt_any   = a_gnt | b_gnt;
    gnt_we    = a_gnt ? a_we    : b_we;
    gnt_addr  = a_gnt ? a_addr  : b_addr;
    gnt_wdata = a_gnt ? a_wdata : b_wdata;

    mem_dre    = gnt_any & ~gnt_we;
    mem_dwe    = gnt_any & gnt_we;
    mem_draddr = mem_dre ? gnt_addr  : '0;
    mem_dwaddr = mem_dwe ? gnt_addr  : '0;
    mem_din    = mem_dwe ? gnt_wdata : '0;
  end

  // Stage p0..p(RD_LAT-1): response tracking, advances only on enabled edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= 1'b0;
      vld_p        <= '0;
      conflict_cnt <= '0;
    end else if (gwe) begin
      if (a_gnt)
        ptr <= 1'b1;
      else if (b_gnt)
        ptr <= 1'b0;
      vld_p[0] <= mem_dre;
      for (int i = 1; i < RD_LAT; i++)
        vld_p[i] <= vld_p[i-1];
      if (a_req && b_req)
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // Requester id travels beside its valid; only meaningful where vld_p is set
  always_ff @(posedge clk) begin
    if (en) begin
      id_p[0] <= b_gnt;
      for (int i = 1; i < RD_LAT; i++)
        id_p[i] <= id_p[i-1];
    end
  end

  // Head of the pipeline holds through stalls, so rvalid persists while gwe=0
  always_comb begin
    head_vld = vld_p[RD_LAT-1];
    head_id  = id_p[RD_LAT-1];
    a_rvalid = head_vld & ~head_id;
    b_rvalid = head_vld & head_id;
    a_rdata  = a_rvalid ? mem_dout : '0;
    b_rdata  = b_rvalid ? mem_dout : '0;
  end

endmodule
